// File: rtl/trap_sequencer_pkg.sv
// Purpose: shared types and constants for the trap/return/sleep sequencer.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
// Contents: pc_sel_t, trap_state_e, cause constants, highestIrq() priority helper.
package trap_sequencer_pkg;

   // PC sources; PC_BRANCH/PC_JUMP are owned by control, listed so the encoding is shared.
   typedef enum logic [2:0] {
      PC_PLUS_4 = 3'd0,
      PC_BRANCH = 3'd1,
      PC_JUMP   = 3'd2,
      PC_MTVEC  = 3'd3,
      PC_MEPC   = 3'd4
   } pc_sel_t;

   typedef enum logic [2:0] {
      RUN,
      TRAP,
      REDIRECT,
      RET,
      SLEEP
   } trap_state_e;

   localparam int CAUSE_INT_BIT = 31;

   localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
   localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
   localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;

   // Index of the highest set bit; 0 when nothing is set (caller qualifies with |pend).
   function automatic logic [4:0] highestIrq(input logic [30:0] pend);
      logic [4:0] idx;
      idx = '0;
      for (int i = 0; i < 31; i++) begin
         if (pend[i]) idx = 5'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/trap_sequencer_irq_sync.sv
// Purpose: per-bit flop-chain synchroniser for asynchronous level interrupt lines.
// Latency: STAGES cycles (STAGES=0 is a straight wire for already-synchronous sources).
// Backpressure: none; levels are sampled every cycle.
// Ports: clk, rst (sync, active-high), irqAsync[WIDTH] in, irqSync[WIDTH] out.
module irq_sync #(
   parameter int WIDTH  = 12,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] irqAsync,
   output logic [WIDTH-1:0] irqSync
);

   generate
      if (STAGES == 0) begin : gPass
         assign irqSync = irqAsync;
      end else begin : gChain
         logic [WIDTH-1:0] chain [STAGES];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < STAGES; s++) chain[s] <= '0;
            end else begin
               chain[0] <= irqAsync;
               for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
            end
         end

         assign irqSync = chain[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/trap_sequencer.sv
// Purpose: multi-cycle trap / MRET / WFI sequencer for the RV32 core, with interrupts.
// Latency: trap = detect cycle + TRAP + REDIRECT (handler fetch 2 cycles after detect); MRET 1 cycle.
// Backpressure: holds the pipeline with stall_o while sequencing or sleeping.
// Ports: clk/rst (sync, active-high); decoded exc/MRET/WFI requests, pc_i, mtvec_i, MIE, mie_i,
//        irq_i in; mip_o, stall_o, flush_o, pc_sel_o, trap_target_o, mepc/mcause write strobes
//        and data, mstatus_trap_o/mstatus_mret_o pulses, sleeping_o out.
// Build option: define TRAP_VECTORED_EN to honour mtvec vectored mode for interrupts.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int NUM_IRQ         = 12,
   parameter int IRQ_SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid_i,
   input  logic                exc_request_i,
   input  logic [XLEN-1:0]     exc_cause_i,
   input  logic                exc_ret_i,
   input  logic                wfi_i,
   input  logic [XLEN-1:0]     pc_i,
   input  logic [XLEN-1:0]     mtvec_i,
   input  logic                mstatus_mie_i,
   input  logic [NUM_IRQ-1:0]  mie_i,
   input  logic [NUM_IRQ-1:0]  irq_i,
   output logic [NUM_IRQ-1:0]  mip_o,
   output logic                stall_o,
   output logic                flush_o,
   output pc_sel_t             pc_sel_o,
   output logic [XLEN-1:0]     trap_target_o,
   output logic                mepc_we_o,
   output logic                mcause_we_o,
   output logic [XLEN-1:0]     mepc_wdata_o,
   output logic [XLEN-1:0]     mcause_wdata_o,
   output logic                mstatus_trap_o,
   output logic                mstatus_mret_o,
   output logic                sleeping_o
);

   trap_state_e       state, stateNext;
   logic [XLEN-1:0]   mepcQ, mcauseQ, trapTargetQ;
   logic              capture;
   logic [XLEN-1:0]   causeSel, targetSel;
   logic [NUM_IRQ-1:0] intPend;
   logic              anyPend, intTaken;
   logic [4:0]        intIdx;
   logic [XLEN-1:0]   intCause, excCause, baseAddr;
   logic              unusedBits;

   irq_sync #(
      .WIDTH  (NUM_IRQ),
      .STAGES (IRQ_SYNC_STAGES)
   ) uIrqSync (
      .clk      (clk),
      .rst      (rst),
      .irqAsync (irq_i),
      .irqSync  (mip_o)
   );

   assign intPend  = mip_o & mie_i;
   assign anyPend  = |intPend;
   assign intTaken = mstatus_mie_i & anyPend;
   assign intIdx   = highestIrq(31'(intPend));

   always_comb begin
      intCause                = '0;
      intCause[CAUSE_INT_BIT] = 1'b1;
      intCause[4:0]           = intIdx;
   end

   // Synchronous exceptions can never claim the interrupt bit.
   assign excCause = {1'b0, exc_cause_i[XLEN-2:0]};
   assign baseAddr = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   // Only interrupts vector; the exception branch is reached only when intTaken is low.
   assign targetSel  = (intTaken && (mtvec_i[1:0] == 2'b01))
                       ? baseAddr + (XLEN'(intIdx) << 2) : baseAddr;
   assign unusedBits = exc_cause_i[XLEN-1];
`else
   // Mode bits read as direct in this build.
   assign targetSel  = baseAddr;
   assign unusedBits = ^{exc_cause_i[XLEN-1], mtvec_i[1:0]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         mepcQ       <= '0;
         mcauseQ     <= '0;
         trapTargetQ <= '0;
      end else begin
         state <= stateNext;
         if (capture) begin
            mepcQ       <= pc_i;
            mcauseQ     <= causeSel;
            trapTargetQ <= targetSel;
         end
      end
   end

   always_comb begin
      stateNext      = state;
      stall_o        = 1'b0;
      flush_o        = 1'b0;
      pc_sel_o       = PC_PLUS_4;
      mepc_we_o      = 1'b0;
      mcause_we_o    = 1'b0;
      mstatus_trap_o = 1'b0;
      mstatus_mret_o = 1'b0;
      sleeping_o     = 1'b0;
      capture        = 1'b0;
      causeSel       = excCause;

      // Outputs are quiet while reset is held so no half-finished sequence leaks a strobe.
      if (!rst) begin
         case (state)
            RUN: begin
               if (instr_valid_i) begin
                  if (intTaken) begin
                     flush_o   = 1'b1;
                     stall_o   = 1'b1;
                     capture   = 1'b1;
                     causeSel  = intCause;
                     stateNext = TRAP;
                  end else if (exc_request_i) begin
                     flush_o   = 1'b1;
                     stall_o   = 1'b1;
                     capture   = 1'b1;
                     causeSel  = excCause;
                     stateNext = TRAP;
                  end else if (exc_ret_i) begin
                     stall_o   = 1'b1;
                     stateNext = RET;
                  end else if (wfi_i) begin
                     stall_o   = 1'b1;
                     stateNext = SLEEP;
                  end
               end
            end
            TRAP: begin
               mepc_we_o      = 1'b1;
               mcause_we_o    = 1'b1;
               mstatus_trap_o = 1'b1;
               stall_o        = 1'b1;
               stateNext      = REDIRECT;
            end
            REDIRECT: begin
               pc_sel_o  = PC_MTVEC;
               stateNext = RUN;
            end
            RET: begin
               mstatus_mret_o = 1'b1;
               pc_sel_o       = PC_MEPC;
               stateNext      = RUN;
            end
            SLEEP: begin
               sleeping_o = 1'b1;
               // Wake ignores MIE; the wake cycle releases the stall so fetch moves past WFI.
               if (anyPend) begin
                  stateNext = RUN;
               end else begin
                  stall_o = 1'b1;
               end
            end
            default: stateNext = RUN;
         endcase
      end
   end

   assign mepc_wdata_o   = mepcQ;
   assign mcause_wdata_o = mcauseQ;
   assign trap_target_o  = trapTargetQ;

endmodule

// File: tb/tb_trap_sequencer.sv
// Purpose: self-checking bench for trap_sequencer (table of RUN decisions + hand sequences).
// Latency: n/a.
// Backpressure: n/a.
module tb_trap_sequencer;
   import trap_sequencer_pkg::*;

   logic        clk;
   logic        rst;
   logic        instr_valid_i, exc_request_i, exc_ret_i, wfi_i, mstatus_mie_i;
   logic [31:0] exc_cause_i, pc_i, mtvec_i;
   logic [11:0] mie_i, irq_i, mip_o;
   logic        stall_o, flush_o, mepc_we_o, mcause_we_o;
   logic        mstatus_trap_o, mstatus_mret_o, sleeping_o;
   pc_sel_t     pc_sel_o;
   logic [31:0] trap_target_o, mepc_wdata_o, mcause_wdata_o;

   int total;
   int bad;

   typedef struct packed {
      logic        valid;
      logic        exc;
      logic        ret;
      logic        wfi;
      logic [31:0] cause;
      logic [31:0] pc;
      logic        expFlush;
      logic        expStall;
      logic        expMepcWe;
      logic [31:0] expMcause;
      logic        expMret;
      logic        expSleep;
   } vec_t;

   vec_t vecs [8];

   trap_sequencer #(
      .XLEN            (32),
      .NUM_IRQ         (12),
      .IRQ_SYNC_STAGES (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_valid_i  (instr_valid_i),
      .exc_request_i  (exc_request_i),
      .exc_cause_i    (exc_cause_i),
      .exc_ret_i      (exc_ret_i),
      .wfi_i          (wfi_i),
      .pc_i           (pc_i),
      .mtvec_i        (mtvec_i),
      .mstatus_mie_i  (mstatus_mie_i),
      .mie_i          (mie_i),
      .irq_i          (irq_i),
      .mip_o          (mip_o),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .pc_sel_o       (pc_sel_o),
      .trap_target_o  (trap_target_o),
      .mepc_we_o      (mepc_we_o),
      .mcause_we_o    (mcause_we_o),
      .mepc_wdata_o   (mepc_wdata_o),
      .mcause_wdata_o (mcause_wdata_o),
      .mstatus_trap_o (mstatus_trap_o),
      .mstatus_mret_o (mstatus_mret_o),
      .sleeping_o     (sleeping_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      instr_valid_i = 1'b0;
      exc_request_i = 1'b0;
      exc_ret_i     = 1'b0;
      wfi_i         = 1'b0;
      exc_cause_i   = 32'h0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] expTgt;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      pc_i          = 32'h0;
      mtvec_i       = 32'h400;
      mstatus_mie_i = 1'b0;
      mie_i         = 12'h000;
      irq_i         = 12'h000;

      //                valid exc   ret   wfi   cause          pc            flush stall mepcWe mcause    mret  sleep
      vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd11,        32'h100, 1'b1, 1'b1, 1'b1, 32'd11, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h80000002,  32'h200, 1'b1, 1'b1, 1'b1, 32'd2,  1'b0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd3,         32'h204, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd0,         32'h208, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd0,         32'h20C, 1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd3,         32'h210, 1'b1, 1'b1, 1'b1, 32'd3,  1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd0,         32'h214, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd0,         32'h218, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_stall",    32'(stall_o), 32'd0);
      chk("rst_flush",    32'(flush_o), 32'd0);
      chk("rst_pcsel",    32'(pc_sel_o), 32'(PC_PLUS_4));
      chk("rst_target",   trap_target_o, 32'h0);
      chk("rst_mip",      32'(mip_o), 32'h0);
      chk("rst_sleeping", 32'(sleeping_o), 32'd0);
      chk("rst_mepc_we",  32'(mepc_we_o), 32'd0);

      // Table: one RUN-state decision per row, then the following cycle, then reset.
      for (int i = 0; i < 8; i++) begin
         step();
         instr_valid_i = vecs[i].valid;
         exc_request_i = vecs[i].exc;
         exc_ret_i     = vecs[i].ret;
         wfi_i         = vecs[i].wfi;
         exc_cause_i   = vecs[i].cause;
         pc_i          = vecs[i].pc;
         #1;
         chk($sformatf("row%0d_flush", i), 32'(flush_o), 32'(vecs[i].expFlush));
         chk($sformatf("row%0d_stall", i), 32'(stall_o), 32'(vecs[i].expStall));
         step();
         idle();
         #1;
         chk($sformatf("row%0d_mepc_we", i), 32'(mepc_we_o), 32'(vecs[i].expMepcWe));
         chk($sformatf("row%0d_mret", i),    32'(mstatus_mret_o), 32'(vecs[i].expMret));
         chk($sformatf("row%0d_sleep", i),   32'(sleeping_o), 32'(vecs[i].expSleep));
         if (vecs[i].expMepcWe) begin
            chk($sformatf("row%0d_mcause", i), mcause_wdata_o, vecs[i].expMcause);
            chk($sformatf("row%0d_mepc", i),   mepc_wdata_o, vecs[i].pc);
         end
         step();
         rst = 1'b1;
         step();
         rst = 1'b0;
      end

      // ECALL full timing
      step();
      instr_valid_i = 1'b1; exc_request_i = 1'b1; exc_cause_i = MCAUSE_ECALL_M;
      pc_i = 32'h100; mtvec_i = 32'h400;
      #1;
      chk("ecall_flush", 32'(flush_o), 32'd1);
      step(); idle(); #1;
      chk("ecall_mepc_we",   32'(mepc_we_o), 32'd1);
      chk("ecall_mcause_we", 32'(mcause_we_o), 32'd1);
      chk("ecall_mepc",      mepc_wdata_o, 32'h100);
      chk("ecall_mcause",    mcause_wdata_o, 32'd11);
      chk("ecall_mst_trap",  32'(mstatus_trap_o), 32'd1);
      chk("ecall_stall_t",   32'(stall_o), 32'd1);
      step(); #1;
      chk("ecall_pcsel",     32'(pc_sel_o), 32'(PC_MTVEC));
      chk("ecall_target",    trap_target_o, 32'h400);
      chk("ecall_stall_r",   32'(stall_o), 32'd0);
      chk("ecall_trap_once", 32'(mstatus_trap_o), 32'd0);
      step(); #1;
      chk("ecall_after",     32'(pc_sel_o), 32'(PC_PLUS_4));

      // MRET
      step();
      instr_valid_i = 1'b1; exc_ret_i = 1'b1; pc_i = 32'h120;
      #1;
      chk("mret_flush", 32'(flush_o), 32'd0);
      step(); idle(); #1;
      chk("mret_pulse", 32'(mstatus_mret_o), 32'd1);
      chk("mret_pcsel", 32'(pc_sel_o), 32'(PC_MEPC));
      chk("mret_stall", 32'(stall_o), 32'd0);
      step(); #1;
      chk("mret_once",  32'(mstatus_mret_o), 32'd0);
      chk("mret_stall2", 32'(stall_o), 32'd0);

      // Two interrupts plus a simultaneous exception: highest line wins, exception dropped
      mie_i = 12'hFFF; mstatus_mie_i = 1'b1; mtvec_i = 32'h400;
      irq_i = 12'h880;
      repeat (3) step();
      chk("irq2_mip", 32'(mip_o), 32'h880);
      instr_valid_i = 1'b1; exc_request_i = 1'b1; exc_cause_i = 32'd3; pc_i = 32'h300;
      #1;
      chk("irq2_flush", 32'(flush_o), 32'd1);
      step(); idle(); #1;
      chk("irq2_mcause", mcause_wdata_o, 32'h8000000B);
      chk("irq2_mepc",   mepc_wdata_o, 32'h300);
      step(); #1;
      chk("irq2_target", trap_target_o, 32'h400);
      irq_i = 12'h000; mstatus_mie_i = 1'b0;
      repeat (3) step();

      // Interrupt 7 with mtvec in vectored mode
`ifdef TRAP_VECTORED_EN
      expTgt = 32'h41C;
`else
      expTgt = 32'h400;
`endif
      mstatus_mie_i = 1'b1; mtvec_i = 32'h401; irq_i = 12'h080;
      repeat (3) step();
      instr_valid_i = 1'b1; pc_i = 32'h500;
      #1;
      chk("vec_flush", 32'(flush_o), 32'd1);
      step(); idle(); #1;
      chk("vec_mcause", mcause_wdata_o, 32'h80000007);
      step(); #1;
      chk("vec_pcsel",  32'(pc_sel_o), 32'(PC_MTVEC));
      chk("vec_target", trap_target_o, expTgt);
      irq_i = 12'h000; mstatus_mie_i = 1'b0; mtvec_i = 32'h400;
      repeat (3) step();

      // WFI with MIE=0: sleep, wake on irq 3 after sync + 1 cycles, no trap taken
      mie_i = 12'h008;
      instr_valid_i = 1'b1; wfi_i = 1'b1; pc_i = 32'h700;
      #1;
      chk("wfi_stall", 32'(stall_o), 32'd1);
      step(); idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("wfi_sleep%0d", k), 32'(sleeping_o), 32'd1);
         chk($sformatf("wfi_hold%0d", k),  32'(stall_o), 32'd1);
         step();
      end
      irq_i = 12'h008;
      for (int k = 1; k <= 3; k++) begin
         step(); #1;
         chk($sformatf("wake_sleep%0d", k), 32'(sleeping_o), (k < 3) ? 32'd1 : 32'd0);
         if (k == 2) chk("wake_pcsel", 32'(pc_sel_o), 32'(PC_PLUS_4));
         #1;
      end
      chk("wake_mip", 32'(mip_o), 32'h008);
      chk("wake_noflush", 32'(flush_o), 32'd0);
      step();
      instr_valid_i = 1'b1; pc_i = 32'h704;
      #1;
      chk("wake_no_trap", 32'(flush_o), 32'd0);
      step(); idle(); #1;
      chk("wake_no_mepc", 32'(mepc_we_o), 32'd0);

      // WFI while an enabled line is already pending: one cycle of sleep
      step();
      instr_valid_i = 1'b1; wfi_i = 1'b1; pc_i = 32'h708;
      #1;
      chk("wfi2_stall", 32'(stall_o), 32'd1);
      step(); idle(); #1;
      chk("wfi2_sleep", 32'(sleeping_o), 32'd1);
      step(); #1;
      chk("wfi2_awake", 32'(sleeping_o), 32'd0);
      irq_i = 12'h000;
      repeat (3) step();

      // Reset while in TRAP
      instr_valid_i = 1'b1; exc_request_i = 1'b1; exc_cause_i = MCAUSE_ILLEGAL; pc_i = 32'h600;
      #1;
      chk("rtrap_flush", 32'(flush_o), 32'd1);
      step(); idle(); rst = 1'b1; #1;
      chk("rtrap_we_in_rst", 32'(mepc_we_o), 32'd0);
      step(); rst = 1'b0; #1;
      chk("rtrap_mepc_we", 32'(mepc_we_o), 32'd0);
      chk("rtrap_mst",     32'(mstatus_trap_o), 32'd0);
      chk("rtrap_stall",   32'(stall_o), 32'd0);
      step(); #1;
      chk("rtrap_no_redir", 32'(pc_sel_o), 32'(PC_PLUS_4));
      chk("rtrap_mst2",     32'(mstatus_trap_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
